// File: rtl/instr_loader_pkg.sv
// Shared types and constants for the instruction-memory loader.
package instr_loader_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        WRITE   = 2'd2,
        DONE    = 2'd3
    } loader_state_t;

    localparam int BYTES_PER_WORD  = 4;
    localparam int WORD_BYTES_LOG2 = 2;

endpackage

// File: rtl/instr_mem_loader_word_assembler.sv
// Packs accepted bytes little-endian into a 32-bit word; 'word' already
// contains the byte being accepted this cycle so the caller can capture it.
module word_assembler
    import instr_loader_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clear,
    input  logic [7:0]  byte_in,
    input  logic        accept,
    output logic [31:0] word,
    output logic        word_full
);

    localparam logic [WORD_BYTES_LOG2-1:0] LAST_IDX = WORD_BYTES_LOG2'(BYTES_PER_WORD - 1);

    logic [WORD_BYTES_LOG2-1:0] r_idx;
    logic [31:0]                r_word;
    logic [31:0]                w_merged;

    always_comb begin
        w_merged               = r_word;
        w_merged[8*r_idx +: 8] = byte_in;
    end

    assign word      = accept ? w_merged : r_word;
    assign word_full = accept && (r_idx == LAST_IDX);

    // clear wins over accept so an aborted partial word never leaks into the next load
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_idx  <= '0;
            r_word <= '0;
        end else if (clear) begin
            r_idx  <= '0;
            r_word <= '0;
        end else if (accept) begin
            r_idx  <= r_idx + 1'b1;
            r_word <= w_merged;
        end
    end

endmodule

// File: rtl/instr_mem_loader.sv
// Run-time program loader: byte stream in, one instruction-memory write per
// assembled little-endian word at consecutive 4-aligned addresses.
module instr_mem_loader
    import instr_loader_pkg::*;
#(
    parameter int          DEPTH     = 1024,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int          CNT_W     = 11
)
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             abort,
    input  logic [CNT_W-1:0] word_count,
    input  logic [7:0]       byte_in,
    input  logic             byte_valid,
    output logic             byte_ready,
    output logic             mem_we,
    output logic [31:0]      mem_addr,
    output logic [31:0]      mem_wdata,
    output logic             busy,
    output logic             done,
    output logic             error
);

    loader_state_t    r_state;
    loader_state_t    w_next;
    logic [CNT_W-1:0] r_count;
    logic [CNT_W-1:0] r_word_idx;
    logic             r_byte_ready;
    logic             r_mem_we;
    logic [31:0]      r_mem_addr;
    logic [31:0]      r_mem_wdata;
    logic             r_busy;
    logic             r_done;
    logic             r_error;

    logic             w_accept;
    logic             w_clear;
    logic             w_start_ok;
    logic             w_reject;
    logic             w_count_over;
    logic             w_count_zero;
    logic             w_last_word;
    logic [31:0]      w_word;
    logic             w_word_full;
    logic [31:0]      w_addr;

    assign w_accept     = byte_valid & r_byte_ready;
    assign w_clear      = abort | w_start_ok;
    assign w_count_over = int'(word_count) > DEPTH;
    assign w_count_zero = (word_count == '0);
    assign w_last_word  = ((r_word_idx + CNT_W'(1)) == r_count);
    assign w_addr       = BASE_ADDR + (32'(r_word_idx) << WORD_BYTES_LOG2);

    word_assembler u_asm (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear     (w_clear),
        .byte_in   (byte_in),
        .accept    (w_accept),
        .word      (w_word),
        .word_full (w_word_full)
    );

    always_comb begin
        w_next     = r_state;
        w_start_ok = 1'b0;
        w_reject   = 1'b0;
        case (r_state)
            IDLE: begin
                if (start) begin
                    if (w_count_over) begin
                        w_reject = 1'b1;
                    end else if (w_count_zero) begin
                        w_next = DONE;
                    end else begin
                        w_next     = COLLECT;
                        w_start_ok = 1'b1;
                    end
                end
            end
            COLLECT: if (w_word_full) w_next = WRITE;
            WRITE:   w_next = w_last_word ? DONE : COLLECT;
            DONE:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
        // abort overrides every transition, including a start seen in the same cycle
        if (abort) begin
            w_next     = IDLE;
            w_start_ok = 1'b0;
            w_reject   = 1'b0;
        end
    end

    // Outputs are registered from the next state so they line up with the state they describe
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= IDLE;
            r_count      <= '0;
            r_word_idx   <= '0;
            r_byte_ready <= 1'b0;
            r_mem_we     <= 1'b0;
            r_mem_addr   <= BASE_ADDR;
            r_mem_wdata  <= '0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_error      <= 1'b0;
        end else begin
            r_state      <= w_next;
            r_byte_ready <= (w_next == COLLECT);
            r_mem_we     <= (w_next == WRITE);
            r_busy       <= (w_next == COLLECT) || (w_next == WRITE);
            r_done       <= (w_next == DONE);
            r_error      <= w_reject;
            if (w_start_ok) begin
                r_count    <= word_count;
                r_word_idx <= '0;
            end else if (r_state == WRITE) begin
                r_word_idx <= r_word_idx + CNT_W'(1);
            end
            if (w_next == WRITE) begin
                r_mem_addr  <= w_addr;
                r_mem_wdata <= w_word;
            end
        end
    end

    assign byte_ready = r_byte_ready;
    assign mem_we     = r_mem_we;
    assign mem_addr   = r_mem_addr;
    assign mem_wdata  = r_mem_wdata;
    assign busy       = r_busy;
    assign done       = r_done;
    assign error      = r_error;

endmodule

// File: tb/tb_instr_mem_loader.sv
// Directed bench for instr_mem_loader; a second instance with BASE_ADDR=0x100 shares the stimulus.
module tb_instr_mem_loader;

    localparam int CNT_W = 11;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             start = 1'b0;
    logic             abort = 1'b0;
    logic [CNT_W-1:0] word_count = '0;
    logic [7:0]       byte_in = '0;
    logic             byte_valid = 1'b0;

    logic        byte_ready, mem_we, busy, done, error;
    logic [31:0] mem_addr, mem_wdata;
    logic        b_byte_ready, b_mem_we, b_busy, b_done, b_error;
    logic [31:0] b_mem_addr, b_mem_wdata;

    instr_mem_loader #(.DEPTH(1024), .BASE_ADDR(32'h0000_0000), .CNT_W(CNT_W)) u_dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .word_count(word_count),
        .byte_in(byte_in), .byte_valid(byte_valid), .byte_ready(byte_ready),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .busy(busy), .done(done), .error(error)
    );

    instr_mem_loader #(.DEPTH(1024), .BASE_ADDR(32'h0000_0100), .CNT_W(CNT_W)) u_dut_b (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .word_count(word_count),
        .byte_in(byte_in), .byte_valid(byte_valid), .byte_ready(b_byte_ready),
        .mem_we(b_mem_we), .mem_addr(b_mem_addr), .mem_wdata(b_mem_wdata),
        .busy(b_busy), .done(b_done), .error(b_error)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] wr_addr[$];
    logic [31:0] wr_data[$];
    int          wr_cyc[$];
    int          done_cnt, done_cyc, err_cnt, err_cyc, ready_gap, busy_seen;
    int          b_wr_cnt;
    logic [31:0] b_last_addr, b_last_data;
    logic [7:0]  stim[16];
    int          acc_cyc[16];
    int          start_cyc;

    always @(negedge clk) begin
        if (rst_n) begin
            if (mem_we) begin
                wr_addr.push_back(mem_addr);
                wr_data.push_back(mem_wdata);
                wr_cyc.push_back(cyc);
            end
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
            end
            if (error) begin
                err_cnt++;
                err_cyc = cyc;
            end
            if (busy) busy_seen = 1;
            if (busy && !mem_we && !byte_ready) ready_gap++;
            if (b_mem_we) begin
                b_wr_cnt++;
                b_last_addr = b_mem_addr;
                b_last_data = b_mem_wdata;
            end
        end
    end

    task automatic clear_log();
        wr_addr.delete();
        wr_data.delete();
        wr_cyc.delete();
        done_cnt  = 0;
        done_cyc  = -1;
        err_cnt   = 0;
        err_cyc   = -1;
        ready_gap = 0;
        busy_seen = 0;
        b_wr_cnt  = 0;
        b_last_addr = 'x;
        b_last_data = 'x;
    endtask

    task automatic pad_log();
        while (wr_addr.size() < 4) begin
            wr_addr.push_back('x);
            wr_data.push_back('x);
            wr_cyc.push_back(-100);
        end
    endtask

    task automatic do_start(input int cnt);
        @(negedge clk);
        start      = 1'b1;
        word_count = CNT_W'(cnt);
        start_cyc  = cyc;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic push_bytes(input int first, input int last, input bit toggle);
        int idx   = first;
        int guard = 0;
        while (idx < last && guard < 60) begin
            @(negedge clk);
            if (toggle && (guard % 2 == 1)) begin
                byte_valid = 1'b0;
            end else begin
                byte_valid = 1'b1;
                byte_in    = stim[idx];
                if (byte_ready) begin
                    acc_cyc[idx] = cyc;
                    idx++;
                end
            end
            guard++;
        end
        @(negedge clk);
        byte_valid = 1'b0;
        n_checks++;
        if (idx !== last) begin
            n_fail++;
            $display("FAIL push_timeout: accepted up to byte %0d, required %0d", idx, last);
        end
    endtask

    task automatic load_prog1();
        stim[0] = 8'h13; stim[1] = 8'h00; stim[2] = 8'h00; stim[3] = 8'h00;
        stim[4] = 8'h93; stim[5] = 8'h00; stim[6] = 8'h10; stim[7] = 8'h00;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++; if (byte_ready !== 1'b0) begin n_fail++; $display("FAIL rst_byte_ready: got %b expected 0", byte_ready); end
        n_checks++; if (mem_we !== 1'b0) begin n_fail++; $display("FAIL rst_mem_we: got %b expected 0", mem_we); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy: got %b expected 0", busy); end
        n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL rst_done: got %b expected 0", done); end
        n_checks++; if (error !== 1'b0) begin n_fail++; $display("FAIL rst_error: got %b expected 0", error); end
        n_checks++; if (mem_addr !== 32'h0) begin n_fail++; $display("FAIL rst_mem_addr: got %h expected 00000000", mem_addr); end
        n_checks++; if (mem_wdata !== 32'h0) begin n_fail++; $display("FAIL rst_mem_wdata: got %h expected 00000000", mem_wdata); end
        n_checks++; if (b_mem_addr !== 32'h100) begin n_fail++; $display("FAIL rst_base_addr_b: got %h expected 00000100", b_mem_addr); end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_basic_load();
        clear_log();
        load_prog1();
        do_start(2);
        push_bytes(0, 8, 1'b0);
        repeat (4) @(negedge clk);
        n_checks++; if (wr_addr.size() !== 2) begin n_fail++; $display("FAIL basic_write_count: got %0d expected 2", wr_addr.size()); end
        n_checks++; if (done_cnt !== 1) begin n_fail++; $display("FAIL basic_done_count: got %0d expected 1", done_cnt); end
        pad_log();
        n_checks++; if (wr_addr[0] !== 32'h0) begin n_fail++; $display("FAIL basic_addr0: got %h expected 00000000", wr_addr[0]); end
        n_checks++; if (wr_data[0] !== 32'h0000_0013) begin n_fail++; $display("FAIL basic_data0: got %h expected 00000013", wr_data[0]); end
        n_checks++; if (wr_addr[1] !== 32'h4) begin n_fail++; $display("FAIL basic_addr1: got %h expected 00000004", wr_addr[1]); end
        n_checks++; if (wr_data[1] !== 32'h0010_0093) begin n_fail++; $display("FAIL basic_data1: got %h expected 00100093", wr_data[1]); end
        n_checks++; if (acc_cyc[3] - acc_cyc[0] !== 3) begin n_fail++; $display("FAIL basic_byte_spacing: got %0d expected 3", acc_cyc[3] - acc_cyc[0]); end
        n_checks++; if (wr_cyc[0] !== acc_cyc[3] + 1) begin n_fail++; $display("FAIL basic_we_latency: got cycle %0d expected %0d", wr_cyc[0], acc_cyc[3] + 1); end
        n_checks++; if (acc_cyc[4] - acc_cyc[0] !== 5) begin n_fail++; $display("FAIL basic_throughput: got %0d expected 5", acc_cyc[4] - acc_cyc[0]); end
        n_checks++; if (done_cyc !== wr_cyc[1] + 1) begin n_fail++; $display("FAIL basic_done_timing: got cycle %0d expected %0d", done_cyc, wr_cyc[1] + 1); end
    endtask

    task automatic test_toggle_valid();
        clear_log();
        load_prog1();
        do_start(2);
        push_bytes(0, 8, 1'b1);
        repeat (4) @(negedge clk);
        n_checks++; if (wr_addr.size() !== 2) begin n_fail++; $display("FAIL toggle_write_count: got %0d expected 2", wr_addr.size()); end
        n_checks++; if (ready_gap !== 0) begin n_fail++; $display("FAIL toggle_ready_gap: got %0d cycles expected 0", ready_gap); end
        pad_log();
        n_checks++; if (wr_data[0] !== 32'h0000_0013) begin n_fail++; $display("FAIL toggle_data0: got %h expected 00000013", wr_data[0]); end
        n_checks++; if (wr_data[1] !== 32'h0010_0093) begin n_fail++; $display("FAIL toggle_data1: got %h expected 00100093", wr_data[1]); end
        n_checks++; if (wr_addr[1] !== 32'h4) begin n_fail++; $display("FAIL toggle_addr1: got %h expected 00000004", wr_addr[1]); end
        n_checks++; if (wr_cyc[0] !== acc_cyc[3] + 1) begin n_fail++; $display("FAIL toggle_we_after_4th: got cycle %0d expected %0d", wr_cyc[0], acc_cyc[3] + 1); end
        n_checks++; if (done_cnt !== 1) begin n_fail++; $display("FAIL toggle_done_count: got %0d expected 1", done_cnt); end
    endtask

    task automatic test_bounds();
        clear_log();
        do_start(1025);
        repeat (3) @(negedge clk);
        n_checks++; if (err_cnt !== 1) begin n_fail++; $display("FAIL over_error_count: got %0d expected 1", err_cnt); end
        n_checks++; if (err_cyc !== start_cyc + 1) begin n_fail++; $display("FAIL over_error_timing: got cycle %0d expected %0d", err_cyc, start_cyc + 1); end
        n_checks++; if (busy_seen !== 0) begin n_fail++; $display("FAIL over_busy: got %0d expected 0", busy_seen); end
        n_checks++; if (wr_addr.size() !== 0) begin n_fail++; $display("FAIL over_writes: got %0d expected 0", wr_addr.size()); end
        n_checks++; if (done_cnt !== 0) begin n_fail++; $display("FAIL over_done: got %0d expected 0", done_cnt); end
        clear_log();
        do_start(0);
        repeat (3) @(negedge clk);
        n_checks++; if (done_cnt !== 1) begin n_fail++; $display("FAIL zero_done_count: got %0d expected 1", done_cnt); end
        n_checks++; if (done_cyc !== start_cyc + 1) begin n_fail++; $display("FAIL zero_done_timing: got cycle %0d expected %0d", done_cyc, start_cyc + 1); end
        n_checks++; if (wr_addr.size() !== 0) begin n_fail++; $display("FAIL zero_writes: got %0d expected 0", wr_addr.size()); end
        n_checks++; if (err_cnt !== 0) begin n_fail++; $display("FAIL zero_error: got %0d expected 0", err_cnt); end
        n_checks++; if (busy_seen !== 0) begin n_fail++; $display("FAIL zero_busy: got %0d expected 0", busy_seen); end
    endtask

    task automatic test_abort();
        clear_log();
        load_prog1();
        do_start(3);
        push_bytes(0, 6, 1'b0);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL abort_busy: got %b expected 0", busy); end
        n_checks++; if (byte_ready !== 1'b0) begin n_fail++; $display("FAIL abort_ready: got %b expected 0", byte_ready); end
        repeat (4) @(negedge clk);
        n_checks++; if (wr_addr.size() !== 1) begin n_fail++; $display("FAIL abort_write_count: got %0d expected 1", wr_addr.size()); end
        n_checks++; if (done_cnt !== 0) begin n_fail++; $display("FAIL abort_done: got %0d expected 0", done_cnt); end
        pad_log();
        n_checks++; if (wr_addr[0] !== 32'h0) begin n_fail++; $display("FAIL abort_addr0: got %h expected 00000000", wr_addr[0]); end
        clear_log();
        stim[0] = 8'hAA; stim[1] = 8'hBB; stim[2] = 8'hCC; stim[3] = 8'hDD;
        do_start(1);
        push_bytes(0, 4, 1'b0);
        repeat (3) @(negedge clk);
        n_checks++; if (wr_addr.size() !== 1) begin n_fail++; $display("FAIL reload_write_count: got %0d expected 1", wr_addr.size()); end
        n_checks++; if (done_cnt !== 1) begin n_fail++; $display("FAIL reload_done: got %0d expected 1", done_cnt); end
        pad_log();
        n_checks++; if (wr_addr[0] !== 32'h0) begin n_fail++; $display("FAIL reload_addr: got %h expected 00000000", wr_addr[0]); end
        n_checks++; if (wr_data[0] !== 32'hDDCC_BBAA) begin n_fail++; $display("FAIL reload_data: got %h expected ddccbbaa", wr_data[0]); end
    endtask

    task automatic test_reset_mid_load();
        clear_log();
        load_prog1();
        do_start(2);
        push_bytes(0, 2, 1'b0);
        n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL midrst_pre_busy: got %b expected 1", busy); end
        #1 rst_n = 1'b0;
        #1;
        n_checks++; if (byte_ready !== 1'b0) begin n_fail++; $display("FAIL midrst_ready: got %b expected 0", byte_ready); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL midrst_busy: got %b expected 0", busy); end
        n_checks++; if (mem_we !== 1'b0) begin n_fail++; $display("FAIL midrst_we: got %b expected 0", mem_we); end
        n_checks++; if (mem_addr !== 32'h0) begin n_fail++; $display("FAIL midrst_addr: got %h expected 00000000", mem_addr); end
        n_checks++; if (b_mem_addr !== 32'h100) begin n_fail++; $display("FAIL midrst_addr_b: got %h expected 00000100", b_mem_addr); end
        @(negedge clk);
        rst_n = 1'b1;
        clear_log();
        stim[0] = 8'h6F; stim[1] = 8'h00; stim[2] = 8'h00; stim[3] = 8'h00;
        do_start(1);
        push_bytes(0, 4, 1'b0);
        repeat (3) @(negedge clk);
        n_checks++; if (b_wr_cnt !== 1) begin n_fail++; $display("FAIL base_write_count: got %0d expected 1", b_wr_cnt); end
        n_checks++; if (b_last_addr !== 32'h100) begin n_fail++; $display("FAIL base_addr: got %h expected 00000100", b_last_addr); end
        n_checks++; if (b_last_data !== 32'h0000_006F) begin n_fail++; $display("FAIL base_data: got %h expected 0000006f", b_last_data); end
    endtask

    task automatic test_start_ignored();
        clear_log();
        load_prog1();
        do_start(2);
        push_bytes(0, 3, 1'b0);
        do_start(1);
        push_bytes(3, 8, 1'b0);
        repeat (4) @(negedge clk);
        n_checks++; if (err_cnt !== 0) begin n_fail++; $display("FAIL ignore_error: got %0d expected 0", err_cnt); end
        n_checks++; if (wr_addr.size() !== 2) begin n_fail++; $display("FAIL ignore_write_count: got %0d expected 2", wr_addr.size()); end
        n_checks++; if (done_cnt !== 1) begin n_fail++; $display("FAIL ignore_done: got %0d expected 1", done_cnt); end
        pad_log();
        n_checks++; if (wr_data[1] !== 32'h0010_0093) begin n_fail++; $display("FAIL ignore_data1: got %h expected 00100093", wr_data[1]); end
    endtask

    initial begin
        clear_log();
        for (int i = 0; i < 16; i++) begin
            stim[i]    = 8'h00;
            acc_cyc[i] = 0;
        end
        test_reset();
        test_basic_load();
        test_toggle_valid();
        test_bounds();
        test_abort();
        test_reset_mid_load();
        test_start_ignored();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached before completion");
        $fatal(1);
    end

endmodule
